// File: rtl/sram_rgb_avg_streamer.sv
// SRAM pixel fetcher for the display path: reads packed RGB triples, applies a 2-tap
// horizontal average per row and buffers results in a small FIFO for the VGA side.
module sram_rgb_avg_streamer #(
  parameter logic [17:0] BASE_ADDR    = 18'd0,
  parameter int unsigned IMG_WIDTH    = 320,
  parameter int unsigned IMG_HEIGHT   = 240,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned SRAM_LATENCY = 2
) (
  input  logic        Clock_50,
  input  logic        Reset,
  input  logic        Start,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data,
  output logic        Pixel_valid,
  input  logic        Pixel_pop,
  output logic [23:0] Pixel_RGB,
  output logic        Busy,
  output logic        Frame_done
);

  localparam int unsigned FRAME_WORDS = IMG_WIDTH * IMG_HEIGHT * 3 / 2;
  localparam logic [17:0] LAST_ADDR   = BASE_ADDR + 18'(FRAME_WORDS - 1);
  localparam int unsigned PW          = $clog2(FIFO_DEPTH);
  localparam int unsigned CW          = PW + 1;
  localparam int unsigned XW          = $clog2(IMG_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD, S_DRAIN} state_t;

  state_t          state, state_n;
  logic [1:0]      phase, phase_n;
  logic            issue_c, triple_c, done_c, space_ok_c;

  logic [17:0]     addr;
  logic [CW-1:0]   count, pend;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [23:0]     fifo_mem [FIFO_DEPTH];
  logic [XW-1:0]   col;
  logic [23:0]     prev_raw;
  logic [15:0]     w0;
  logic [7:0]      r1;
  logic            busy_q, frame_done_q;

  logic [SRAM_LATENCY-1:0] tag_vld;
  logic [1:0]              tag_ph [SRAM_LATENCY];

  logic            ret_vld_c, push_c, pop_c;
  logic [1:0]      ret_ph_c;
  logic [23:0]     raw_c, out_px_c;

  function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
    return 8'((9'(a) + 9'(b)) >> 1);
  endfunction

  // Pending pixels are already committed to FIFO slots, so they count against space.
  always_comb space_ok_c = (32'(count) + 32'(pend) + 32'd2) <= 32'(FIFO_DEPTH);

  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      state <= S_IDLE;
      phase <= 2'd0;
    end else begin
      state <= state_n;
      phase <= phase_n;
    end
  end

  // Start cycle already has BASE_ADDR on the bus, so it doubles as the first word read.
  always_comb begin
    state_n  = state;
    phase_n  = phase;
    issue_c  = 1'b0;
    triple_c = 1'b0;
    done_c   = 1'b0;
    case (state)
      S_IDLE: begin
        if (Start) begin
          if (space_ok_c) begin
            issue_c  = 1'b1;
            triple_c = 1'b1;
            phase_n  = 2'd1;
            state_n  = S_ISSUE;
          end else begin
            state_n = S_HOLD;
          end
        end
      end
      S_ISSUE: begin
        if (phase == 2'd0) begin
          if (space_ok_c) begin
            issue_c  = 1'b1;
            triple_c = 1'b1;
            phase_n  = 2'd1;
          end else begin
            state_n = S_HOLD;
          end
        end else begin
          issue_c = 1'b1;
          if (phase == 2'd2) begin
            phase_n = 2'd0;
            if (addr == LAST_ADDR) state_n = S_DRAIN;
          end else begin
            phase_n = 2'd2;
          end
        end
      end
      S_HOLD: begin
        if (space_ok_c) begin
          issue_c  = 1'b1;
          triple_c = 1'b1;
          phase_n  = 2'd1;
          state_n  = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (count == '0 && pend == '0) begin
          done_c  = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Tag each read with its word phase so returning data can be steered.
  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      tag_vld <= '0;
      for (int i = 0; i < int'(SRAM_LATENCY); i++) tag_ph[i] <= 2'd0;
    end else begin
      tag_vld[0] <= issue_c;
      tag_ph[0]  <= phase;
      for (int i = 1; i < int'(SRAM_LATENCY); i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_ph[i]  <= tag_ph[i-1];
      end
    end
  end

  always_comb begin
    ret_vld_c = tag_vld[SRAM_LATENCY-1];
    ret_ph_c  = tag_ph[SRAM_LATENCY-1];
    push_c    = ret_vld_c && (ret_ph_c != 2'd0);
    pop_c     = Pixel_pop && (count != '0);
    raw_c     = (ret_ph_c == 2'd1) ? {w0, SRAM_read_data[15:8]} : {r1, SRAM_read_data};
    out_px_c  = raw_c;
    if (col != '0) begin
      out_px_c = {avg8(prev_raw[23:16], raw_c[23:16]),
                  avg8(prev_raw[15:8],  raw_c[15:8]),
                  avg8(prev_raw[7:0],   raw_c[7:0])};
    end
  end

  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      addr         <= BASE_ADDR;
      count        <= '0;
      pend         <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      col          <= '0;
      prev_raw     <= '0;
      w0           <= '0;
      r1           <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      if (done_c) begin
        addr <= BASE_ADDR;
      end else if (issue_c && addr != LAST_ADDR) begin
        addr <= addr + 18'd1;
      end
      pend  <= pend + (triple_c ? CW'(2) : CW'(0)) - CW'(push_c);
      count <= count + CW'(push_c) - CW'(pop_c);
      if (ret_vld_c && ret_ph_c == 2'd0) w0 <= SRAM_read_data;
      if (ret_vld_c && ret_ph_c == 2'd1) r1 <= SRAM_read_data[7:0];
      if (push_c) begin
        wr_ptr   <= wr_ptr + PW'(1);
        prev_raw <= raw_c;
        col      <= (col == XW'(IMG_WIDTH - 1)) ? '0 : col + XW'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + PW'(1);
      busy_q       <= (state_n != S_IDLE);
      frame_done_q <= done_c;
    end
  end

  // Storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge Clock_50) begin
    if (push_c) fifo_mem[wr_ptr] <= out_px_c;
  end

  assign SRAM_address = addr;
  assign SRAM_we_n    = 1'b1;
  assign Pixel_valid  = (count != '0);
  assign Pixel_RGB    = Pixel_valid ? fifo_mem[rd_ptr] : 24'd0;
  assign Busy         = busy_q;
  assign Frame_done   = frame_done_q;

endmodule

// File: tb/tb_sram_rgb_avg_streamer.sv
// Scoreboard bench for sram_rgb_avg_streamer on a reduced 16x6 image with an SRAM model.
module tb_sram_rgb_avg_streamer;

  localparam int          W     = 16;
  localparam int          H     = 6;
  localparam int          NPIX  = W * H;
  localparam int          WORDS = NPIX * 3 / 2;
  localparam int          DEPTH = 8;
  localparam int          LAT   = 2;
  localparam int          BASE  = 40;
  localparam logic [17:0] BASE_A = 18'(BASE);

  logic        Clock_50, Reset, Start, Pixel_pop;
  logic [17:0] SRAM_address;
  logic        SRAM_we_n, Pixel_valid, Busy, Frame_done;
  logic [15:0] SRAM_read_data;
  logic [23:0] Pixel_RGB;

  sram_rgb_avg_streamer #(
    .BASE_ADDR(BASE_A), .IMG_WIDTH(W), .IMG_HEIGHT(H),
    .FIFO_DEPTH(DEPTH), .SRAM_LATENCY(LAT)
  ) dut (
    .Clock_50(Clock_50), .Reset(Reset), .Start(Start),
    .SRAM_address(SRAM_address), .SRAM_we_n(SRAM_we_n), .SRAM_read_data(SRAM_read_data),
    .Pixel_valid(Pixel_valid), .Pixel_pop(Pixel_pop), .Pixel_RGB(Pixel_RGB),
    .Busy(Busy), .Frame_done(Frame_done)
  );

  initial begin
    Clock_50 = 1'b0;
    forever #10 Clock_50 = ~Clock_50;
  end

  // SRAM model: data for an address appears LAT cycles after it was on the bus.
  logic [15:0] mem [512];
  logic [17:0] apipe [LAT];
  always @(posedge Clock_50) begin
    apipe[0] <= SRAM_address;
    for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign SRAM_read_data = mem[apipe[LAT-1][8:0]];

  int          checks = 0;
  int          errors = 0;
  logic [23:0] exp_q [$];
  logic [23:0] got [NPIX];
  int          idx = 0;
  int          done_cnt = 0;
  int          last_frame_pops = 0;
  logic [17:0] last_busy_addr = '0;
  int          pop_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [23:0] get_px(input int i);
    logic [23:0] p = '0;
    for (int j = 0; j < 3; j++) begin
      int k = 3 * i + j;
      logic [15:0] w = mem[BASE + k / 2];
      p = {p[15:0], (k % 2 == 0) ? w[15:8] : w[7:0]};
    end
    return p;
  endfunction

  task automatic set_px(input int i, input logic [23:0] v);
    for (int j = 0; j < 3; j++) begin
      int k = 3 * i + j;
      logic [7:0] b = v[23 - 8*j -: 8];
      if (k % 2 == 0) mem[BASE + k / 2][15:8] = b;
      else            mem[BASE + k / 2][7:0]  = b;
    end
  endtask

  // Reference: first column raw, others the truncated mean with the left neighbour.
  function automatic logic [23:0] exp_px(input int i);
    logic [23:0] cur = get_px(i);
    logic [23:0] prv;
    logic [23:0] r = '0;
    if (i % W == 0) return cur;
    prv = get_px(i - 1);
    for (int c = 0; c < 3; c++) begin
      int s = (int'(prv[8*c +: 8]) + int'(cur[8*c +: 8])) / 2;
      r[8*c +: 8] = 8'(s);
    end
    return r;
  endfunction

  task automatic random_image();
    for (int a = 0; a < 512; a++) mem[a] = 16'($urandom);
  endtask

  task automatic check_reset_values();
    chk("rst_addr",  32'(SRAM_address), 32'(BASE));
    chk("rst_we_n",  32'(SRAM_we_n),    32'd1);
    chk("rst_valid", 32'(Pixel_valid),  32'd0);
    chk("rst_rgb",   32'(Pixel_RGB),    32'd0);
    chk("rst_busy",  32'(Busy),         32'd0);
    chk("rst_done",  32'(Frame_done),   32'd0);
  endtask

  task automatic start_frame();
    int n;
    for (int i = 0; i < NPIX; i++) exp_q.push_back(exp_px(i));
    @(posedge Clock_50); #1 Start = 1'b1;
    @(posedge Clock_50); #1 Start = 1'b0;
    n = 0;
    do begin
      @(negedge Clock_50);
      n++;
    end while (!Pixel_valid && n < 50);
    chk("first_valid_latency_ok", 32'(n <= LAT + 2), 32'd1);
  endtask

  task automatic wait_frame(input bit pulse_start);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < 20000) begin
      @(posedge Clock_50); #1;
      Start = (pulse_start && Busy && $urandom_range(0, 15) == 0);
      n++;
    end
    Start = 1'b0;
    chk("frame_finished_in_time", 32'(n < 20000), 32'd1);
    repeat (4) @(posedge Clock_50);
    #1;
    chk("single_frame_done", 32'(done_cnt), 32'(d0 + 1));
    chk("busy_dropped",      32'(Busy), 32'd0);
    chk("pixels_popped",     32'(last_frame_pops), 32'(NPIX));
    chk("scoreboard_empty",  32'(exp_q.size()), 32'd0);
    chk("last_read_addr",    32'(last_busy_addr), 32'(BASE + WORDS - 1));
  endtask

  // Pop driver: off, every second cycle, or random (includes pops while empty).
  initial begin
    bit tog = 1'b0;
    Pixel_pop = 1'b0;
    forever begin
      @(posedge Clock_50); #1;
      tog = ~tog;
      case (pop_mode)
        1:       Pixel_pop = tog;
        2:       Pixel_pop = 1'($urandom_range(0, 1));
        default: Pixel_pop = 1'b0;
      endcase
    end
  end

  // Monitor: compare each popped pixel against the scoreboard head.
  initial begin
    logic [23:0] e;
    forever begin
      @(negedge Clock_50);
      if (Reset) begin
        exp_q.delete();
        idx = 0;
      end else begin
        if (Busy) last_busy_addr = SRAM_address;
        if (Pixel_valid && Pixel_pop) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pixel_unexpected: got %h, expected no pixel", Pixel_RGB);
          end else begin
            e = exp_q.pop_front();
            chk("pixel", 32'(Pixel_RGB), 32'(e));
          end
          if (idx < NPIX) got[idx] = Pixel_RGB;
          idx++;
        end
        if (Frame_done) begin
          chk("done_busy_low",   32'(Busy),        32'd0);
          chk("done_fifo_empty", 32'(Pixel_valid), 32'd0);
          done_cnt++;
          last_frame_pops = idx;
          idx = 0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    Reset = 1'b1;
    Start = 1'b0;
    random_image();
    repeat (3) @(posedge Clock_50);
    #1 Reset = 1'b0;
    check_reset_values();

    // Directed values, odd sums and a row boundary.
    set_px(0,  24'h102030);
    set_px(1,  24'h405060);
    set_px(2,  24'h010101);
    set_px(3,  24'h020202);
    set_px(W-1, 24'hFFFFFF);
    set_px(W,   24'h000000);
    set_px(W+1, 24'h204060);
    chk("sram_words", 32'({mem[BASE], mem[BASE+1][15:8]}), 32'h102030);
    pop_mode = 1;
    start_frame();
    wait_frame(1'b0);
    chk("px0_raw",      32'(got[0]),   32'h102030);
    chk("px1_avg",      32'(got[1]),   32'h283848);
    chk("odd_sum",      32'(got[3]),   32'h010101);
    chk("row1_col0",    32'(got[W]),   32'h000000);
    chk("row1_col1",    32'(got[W+1]), 32'h102030);

    // Back-pressure: nothing popped, FIFO fills and reads stop.
    random_image();
    pop_mode = 0;
    start_frame();
    repeat (100) @(posedge Clock_50);
    #1;
    chk("bp_reads_stopped", 32'(SRAM_address), 32'(BASE + DEPTH / 2 * 3));
    chk("bp_valid",         32'(Pixel_valid),  32'd1);
    pop_mode = 1;
    wait_frame(1'b0);

    // Full random frame at one pop every second cycle.
    random_image();
    start_frame();
    wait_frame(1'b0);

    // Reset mid-frame.
    random_image();
    pop_mode = 2;
    start_frame();
    n = 0;
    while (idx < 50 && n < 5000) begin
      @(posedge Clock_50);
      n++;
    end
    chk("reset_point_reached", 32'(n < 5000), 32'd1);
    #1 Reset = 1'b1;
    @(posedge Clock_50); #1 Reset = 1'b0;
    check_reset_values();

    // Restart after reset, with Start pulses while busy and random pops.
    random_image();
    start_frame();
    wait_frame(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
